// File: rtl/median_pkg.sv
// Shared types and defaults for the median filter column-tap path.
// Holds image-size defaults, the fill/run FSM encoding and its line-end transition.
package median_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 640;
    localparam int IMG_H_DEF  = 480;
    localparam int COL_W_DEF  = 10;

    typedef enum logic [1:0] {
        S_FILL0 = 2'd0,
        S_FILL1 = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    // Evaluated only on the pixel that closes a line.
    function automatic state_e fsm_next(input state_e s, input logic last_row);
        state_e n;
        case (s)
            S_FILL0: n = S_FILL1;
            S_FILL1: n = S_RUN;
            S_RUN:   n = last_row ? S_FILL0 : S_RUN;
            default: n = S_FILL0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/median_window_gen_line_buf.sv
// One line of pixel storage: asynchronous read, synchronous write on a shared address.
// A same-cycle read returns the contents from before the write edge.
module line_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Storage is deliberately left unreset; the FSM never exposes stale lines.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3-row column-tap generator feeding the median sorter's d1/d2/d3 inputs.
// Optional top-border replication is built when MEDIAN_WIN_BORDER_REPLICATE_EN is defined.
module median_window_gen
    import median_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int COL_W  = COL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof_i,
    input  logic              pix_vld_i,
    input  logic [DATA_W-1:0] pix_i,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic [DATA_W-1:0] d3_o,
    output logic              win_vld_o,
    output logic              eol_o,
    output logic              eof_o
);

    localparam int               LB_AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] ROW_LAST = COL_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] CNT_ZERO = {COL_W{1'b0}};
    localparam logic [COL_W-1:0] CNT_ONE  = {{(COL_W-1){1'b0}}, 1'b1};

    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  r_row;
    state_e            r_state;

    logic [COL_W-1:0]  w_col;
    logic [COL_W-1:0]  w_row;
    state_e            w_state;
    logic [COL_W-1:0]  w_col_nxt;
    logic [COL_W-1:0]  w_row_nxt;
    state_e            w_state_nxt;
    logic              w_last_col;
    logic              w_last_row;
    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;
    logic [DATA_W-1:0] w_d1;
    logic [DATA_W-1:0] w_d2;
    logic              w_win;
    logic              w_eol;

    // A qualified sof realigns the current pixel to the frame origin before anything uses it.
    always_comb begin
        if (sof_i) begin
            w_col   = CNT_ZERO;
            w_row   = CNT_ZERO;
            w_state = S_FILL0;
        end else begin
            w_col   = r_col;
            w_row   = r_row;
            w_state = r_state;
        end
    end

    assign w_last_col = (w_col == COL_LAST);
    assign w_last_row = (w_row == ROW_LAST);

    // Raster advance; the FSM only moves on the pixel that closes a line.
    always_comb begin
        w_col_nxt   = w_col;
        w_row_nxt   = w_row;
        w_state_nxt = w_state;
        if (w_last_col) begin
            w_col_nxt   = CNT_ZERO;
            w_state_nxt = fsm_next(w_state, w_last_row);
            if (w_last_row) begin
                w_row_nxt = CNT_ZERO;
            end else begin
                w_row_nxt = w_row + CNT_ONE;
            end
        end else begin
            w_col_nxt = w_col + CNT_ONE;
        end
    end

    line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (LB_AW)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (pix_vld_i),
        .i_addr  (w_col[LB_AW-1:0]),
        .i_wdata (pix_i),
        .o_rdata (w_lb0_rd)
    );

    // Row-2 buffer is fed from the row-1 buffer's pre-write contents.
    line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (LB_AW)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (pix_vld_i),
        .i_addr  (w_col[LB_AW-1:0]),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

`ifdef MEDIAN_WIN_BORDER_REPLICATE_EN
    // Missing rows above the frame are replaced by the nearest real row.
    always_comb begin
        case (w_state)
            S_FILL0: begin
                w_d1 = pix_i;
                w_d2 = pix_i;
            end
            S_FILL1: begin
                w_d1 = w_lb0_rd;
                w_d2 = w_lb0_rd;
            end
            default: begin
                w_d1 = w_lb1_rd;
                w_d2 = w_lb0_rd;
            end
        endcase
    end

    assign w_win = 1'b1;
    assign w_eol = w_last_col;
`else
    assign w_d1  = w_lb1_rd;
    assign w_d2  = w_lb0_rd;
    assign w_win = (w_state == S_RUN);
    assign w_eol = w_last_col && (w_state == S_RUN);
`endif

    // Position, FSM and output taps; idle cycles hold taps and clear the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= CNT_ZERO;
            r_row     <= CNT_ZERO;
            r_state   <= S_FILL0;
            d1_o      <= {DATA_W{1'b0}};
            d2_o      <= {DATA_W{1'b0}};
            d3_o      <= {DATA_W{1'b0}};
            win_vld_o <= 1'b0;
            eol_o     <= 1'b0;
            eof_o     <= 1'b0;
        end else if (pix_vld_i) begin
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_state   <= w_state_nxt;
            d1_o      <= w_d1;
            d2_o      <= w_d2;
            d3_o      <= pix_i;
            win_vld_o <= w_win;
            eol_o     <= w_eol;
            eof_o     <= w_eol && w_last_row;
        end else begin
            win_vld_o <= 1'b0;
            eol_o     <= 1'b0;
            eof_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_window_gen.sv
// Self-checking bench for median_window_gen on a 4x4 image (pixel = 16*row + col).
// Works in both builds; expectations follow MEDIAN_WIN_BORDER_REPLICATE_EN when defined.
module tb_median_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int CW = 3;

`ifdef MEDIAN_WIN_BORDER_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sof_i;
    logic          pix_vld_i;
    logic [DW-1:0] pix_i;
    logic [DW-1:0] d1_o;
    logic [DW-1:0] d2_o;
    logic [DW-1:0] d3_o;
    logic          win_vld_o;
    logic          eol_o;
    logic          eof_o;

    always #5 clk = ~clk;

    median_window_gen #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H),
        .COL_W  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof_i     (sof_i),
        .pix_vld_i (pix_vld_i),
        .pix_i     (pix_i),
        .d1_o      (d1_o),
        .d2_o      (d2_o),
        .d3_o      (d3_o),
        .win_vld_o (win_vld_o),
        .eol_o     (eol_o),
        .eof_o     (eof_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raster position plus the current frame's pixels as a 2-D image.
    int            m_row;
    int            m_col;
    logic [DW-1:0] img [0:H-1][0:W-1];
    logic          e_vld, e_eol, e_eof, e_known;
    logic [DW-1:0] e_d1, e_d2, e_d3;

    typedef struct {
        logic          vld;
        logic [DW-1:0] pix;
        logic          x_vld;
        logic [DW-1:0] x_d1;
        logic [DW-1:0] x_d2;
        logic [DW-1:0] x_d3;
        logic          x_eol;
        logic          x_eof;
    } vec_t;

    vec_t tbl [0:W*H-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_row   = 0;
        m_col   = 0;
        e_vld   = 1'b0;
        e_eol   = 1'b0;
        e_eof   = 1'b0;
        e_d1    = 8'h00;
        e_d2    = 8'h00;
        e_d3    = 8'h00;
        e_known = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [DW-1:0] p);
        bit in_run;
        if (!v) begin
            e_vld = 1'b0;
            e_eol = 1'b0;
            e_eof = 1'b0;
        end else begin
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = p;
            in_run = (m_row >= 2);
            e_vld  = in_run || REP;
            e_eol  = e_vld && (m_col == W - 1);
            e_eof  = e_eol && (m_row == H - 1);
            e_d3   = p;
            if (in_run) begin
                e_d1 = img[m_row-2][m_col];
                e_d2 = img[m_row-1][m_col];
                e_known = 1'b1;
            end else if (REP && m_row == 0) begin
                e_d1 = p;
                e_d2 = p;
                e_known = 1'b1;
            end else if (REP) begin
                e_d1 = img[0][m_col];
                e_d2 = img[0][m_col];
                e_known = 1'b1;
            end else begin
                e_known = 1'b0;
            end
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row + 1) % H;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".win_vld"}, win_vld_o, e_vld);
        chk({tag, ".eol"}, eol_o, e_eol);
        chk({tag, ".eof"}, eof_o, e_eof);
        if (e_known) begin
            chk({tag, ".d1"}, d1_o, e_d1);
            chk({tag, ".d2"}, d2_o, e_d2);
            chk({tag, ".d3"}, d3_o, e_d3);
        end
    endtask

    // One clock: drive at negedge, sample at the following negedge.
    task automatic cyc(input string tag, input logic v, input logic s, input logic [DW-1:0] p);
        pix_vld_i = v;
        sof_i     = s;
        pix_i     = p;
        model_step(v, s, p);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        pix_vld_i = 1'b0;
        sof_i     = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk({tag, ".rst_d1"}, d1_o, 8'h00);
        chk({tag, ".rst_d2"}, d2_o, 8'h00);
        chk({tag, ".rst_d3"}, d3_o, 8'h00);
        chk({tag, ".rst_vld"}, win_vld_o, 1'b0);
        chk({tag, ".rst_eol"}, eol_o, 1'b0);
        chk({tag, ".rst_eof"}, eof_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [DW-1:0] base, input bit gaps, output int nvld);
        nvld = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cyc(tag, 1'b1, 1'b0, 8'(base + 16 * r + c));
                if (win_vld_o) nvld++;
                if (gaps) cyc({tag, ".idle"}, 1'b0, 1'b0, 8'hEE);
            end
        end
    endtask

    initial begin
        int nvld;
        int first_r;
        rst_n     = 1'b0;
        sof_i     = 1'b0;
        pix_vld_i = 1'b0;
        pix_i     = 8'h00;
        model_reset();

        // Expected taps for one full frame, from the image formula.
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                tbl[r*W+c].vld   = 1'b1;
                tbl[r*W+c].pix   = 8'(16 * r + c);
                tbl[r*W+c].x_vld = (r >= 2) || REP;
                tbl[r*W+c].x_d3  = 8'(16 * r + c);
                tbl[r*W+c].x_d1  = (r == 0) ? 8'(c) : (r == 1) ? 8'(c) : 8'(16 * (r - 2) + c);
                tbl[r*W+c].x_d2  = (r == 0) ? 8'(c) : (r == 1) ? 8'(c) : 8'(16 * (r - 1) + c);
                tbl[r*W+c].x_eol = tbl[r*W+c].x_vld && (c == W - 1);
                tbl[r*W+c].x_eof = tbl[r*W+c].x_eol && (r == H - 1);
            end
        end

        @(negedge clk);
        do_reset("reset");

        // Scenario 1: table-driven full frame.
        nvld = 0;
        for (int i = 0; i < W * H; i++) begin
            pix_vld_i = tbl[i].vld;
            sof_i     = 1'b0;
            pix_i     = tbl[i].pix;
            model_step(tbl[i].vld, 1'b0, tbl[i].pix);
            @(posedge clk);
            @(negedge clk);
            chk("tbl.win_vld", win_vld_o, tbl[i].x_vld);
            chk("tbl.eol", eol_o, tbl[i].x_eol);
            chk("tbl.eof", eof_o, tbl[i].x_eof);
            if (tbl[i].x_vld) begin
                chk("tbl.d1", d1_o, tbl[i].x_d1);
                chk("tbl.d2", d2_o, tbl[i].x_d2);
                chk("tbl.d3", d3_o, tbl[i].x_d3);
                nvld++;
            end
        end
        chk("tbl.valid_count", nvld, REP ? 16 : 8);

        // Scenario 2: same frame with alternating idle cycles.
        frame("gaps", 8'h00, 1'b1, nvld);
        chk("gaps.valid_count", nvld, REP ? 16 : 8);

        // Scenario 4: back-to-back frames with no idle between them.
        frame("b2b_a", 8'h00, 1'b0, nvld);
        frame("b2b_b", 8'h00, 1'b0, nvld);
        chk("b2b.valid_count", nvld, REP ? 16 : 8);

        // Scenario 3: sof mid-row at (r2,c1), then refill with a distinct image.
        for (int i = 0; i < 2 * W + 1; i++) cyc("presof", 1'b1, 1'b0, 8'(16 * (i / W) + i % W));
        cyc("sof", 1'b1, 1'b1, 8'h80);
        chk("sof.win_vld", win_vld_o, REP);
        for (int i = 1; i < 2 * W; i++) cyc("sof_fill", 1'b1, 1'b0, 8'(8'h80 + 16 * (i / W) + i % W));
        cyc("sof_r2c0", 1'b1, 1'b0, 8'hA0);
        chk("sof_refill.vld", win_vld_o, 1'b1);
        chk("sof_refill.d1", d1_o, 8'h80);
        chk("sof_refill.d2", d2_o, 8'h90);
        for (int i = 2 * W + 1; i < W * H; i++) cyc("sof_rest", 1'b1, 1'b0, 8'(8'h80 + 16 * (i / W) + i % W));

        // Scenario 5: reset at (r3,c2), then a clean frame.
        for (int i = 0; i < 3 * W + 2; i++) cyc("prerst", 1'b1, 1'b0, 8'(16 * (i / W) + i % W));
        do_reset("midrst");
        frame("postrst", 8'h00, 1'b0, nvld);
        chk("postrst.valid_count", nvld, REP ? 16 : 8);

        // Randomized traffic: gaps, random sof (qualified or not), occasional reset.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset("rnd");
            end else begin
                cyc("rnd", $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3, 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
